// File: rtl/dma_ch_arb.sv
// Four-channel DMA grant arbiter: highest {req, effective priority} wins (lowest index on ties),
// aged channels are escalated to all-ones, and the grant stays locked until the engine signals done.
module dma_ch_arb #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AGE_W  = 4,
    parameter int unsigned AGE_TH = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] pri0,
    input  logic [DW-1:0] pri1,
    input  logic [DW-1:0] pri2,
    input  logic [DW-1:0] pri3,
    output logic          grant_valid,
    input  logic          grant_ready,
    output logic [1:0]    grant_id,
    output logic [DW-1:0] grant_pri,
    output logic          busy,
    input  logic          done
);

    localparam logic [AGE_W-1:0] AgeMax = AGE_TH[AGE_W-1:0];

    typedef enum logic [1:0] {StIdle, StOffer, StBusy} state_e;

    state_e           state;
    logic [DW-1:0]    pri_arr [4];
    logic [DW-1:0]    eff     [4];
    logic [DW:0]      key     [4];
    logic [AGE_W-1:0] age_q   [4];
    logic [1:0]       w01, w23, win;

    assign pri_arr[0] = pri0;
    assign pri_arr[1] = pri1;
    assign pri_arr[2] = pri2;
    assign pri_arr[3] = pri3;

    // The req bit sits above the priority so a non-requester can never win.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eff[i] = (age_q[i] == AgeMax) ? '1 : pri_arr[i];
            key[i] = {req[i], eff[i]};
        end
    end

    // >= at every node resolves equal keys toward the lower index.
    always_comb begin
        w01 = (key[0] >= key[1]) ? 2'd0 : 2'd1;
        w23 = (key[2] >= key[3]) ? 2'd2 : 2'd3;
        win = (key[w01] >= key[w23]) ? w01 : w23;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            grant_valid <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= 2'd0;
            grant_pri   <= '0;
            for (int i = 0; i < 4; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        grant_id    <= win;
                        grant_pri   <= eff[win];
                        grant_valid <= 1'b1;
                        state       <= StOffer;
                    end
                end
                StOffer: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        busy        <= 1'b1;
                        state       <= StBusy;
                    end
                end
                StBusy: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // A requester in IDLE always causes a decision, so IDLE+req marks the decision edge.
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || (state == StIdle && win == i[1:0])) begin
                    age_q[i] <= '0;
                end else if (state == StIdle && age_q[i] != AgeMax) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dma_ch_arb.md
# dma_ch_arb

Four-channel DMA arbitration stage that sits directly downstream of the four-input priority comparator. Each cycle it forms an effective priority per requesting channel and selects a winner: ties go to the lowest index, and starved channels are escalated by aging. It registers the winner as a grant and holds it through a valid/ready offer to the transfer engine. It then stays locked on that channel until the engine signals completion, so one channel owns the AXI4 datapath per transfer.

## Interface
- DW, 8, per-channel priority width
- AGE_W, 4, aging counter width
- AGE_TH, 15, lost-arbitration count at which a channel is escalated (1..2^AGE_W-1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  4  per-channel transfer request, bit i = channel i
- pri0..pri3  in  DW each  programmed channel priority, larger = more urgent
- grant_valid  out  1  grant offered to transfer engine
- grant_ready  in  1  engine accepts grant
- grant_id  out  2  granted channel, 00=ch0 … 11=ch3
- grant_pri  out  DW  effective priority the winner had at decision
- busy  out  1  grant accepted, transfer in progress
- done  in  1  single-cycle pulse, current transfer finished

## Operation
- Effective priority eff_i = all-ones (DW bits) if age_i == AGE_TH, else pri_i.
- Candidate key k_i = {req_i, eff_i} (DW+1 bits). A non-requesting channel can never beat a requesting one.
- Selection is a fixed tree:
  - w01 = (k0 >= k1) ? ch0 : ch1
  - w23 = (k2 >= k3) ? ch2 : ch3
  - win = (k_w01 >= k_w23) ? w01 : w23
  - Net effect: highest key wins, equal keys resolve to the lowest index.
- FSM states:
  - IDLE: if |req, register win into grant_id, eff_win into grant_pri, set grant_valid, go OFFER. Else stay.
  - OFFER: grant_id/grant_pri/grant_valid held stable. On grant_ready, clear grant_valid, set busy, go BUSY. A request drop by the granted channel does not withdraw the grant.
  - BUSY: on done, clear busy, go IDLE. grant_id and grant_pri keep their last values.
- done is ignored in IDLE and OFFER. grant_ready is ignored outside OFFER.
- Aging is updated only on the IDLE->OFFER edge:
  - winner age cleared
  - any other channel with req=1: age += 1, saturating at AGE_TH
  - channel with req=0: age cleared
- Aging is otherwise held. A channel whose req is low on any cycle is cleared at that edge.
- Priority inputs and req are sampled only at the IDLE decision edge; changes in OFFER/BUSY have no effect on the current grant.

## Timing
- Reset (async assert, sync release):
  - state=IDLE
  - grant_valid=0, busy=0, grant_id=0, grant_pri=0
  - all age_i=0
- Decision latency: req high at edge k in IDLE -> grant_valid=1 after edge k (1 cycle).
- Offer accepted at the edge where grant_valid & grant_ready -> busy=1 after that edge. Zero-wait ready gives grant_valid high exactly one cycle.
- done at edge m in BUSY -> busy=0, state IDLE after m. Earliest next grant_valid is after edge m+1.
- Minimum turnaround: 3 cycles per grant (IDLE, OFFER, BUSY with done in its first cycle).
- done coincident with grant_ready in OFFER: done ignored, enter BUSY.
- Reset asserted in OFFER or BUSY: immediate return to reset values. The engine must discard any in-flight grant.
- All outputs are registered. No combinational path from req, pri or grant_ready to any output.

## Test plan
- Reset then req=0000 for 10 cycles -> grant_valid stays 0, busy 0, grant_id 00.
- req=1111, pri0..3 = 10,40,40,20, ready tied 1 -> grant_id=01, grant_pri=40 one cycle after req; busy next cycle.
- All pri=7, req=1100 -> grant_id=10 (lowest requesting index); pri0=255, req=0010 -> grant_id=01 (non-requester excluded).
- Hold grant_ready=0 for 5 cycles, change pri/req meanwhile -> grant_id/grant_pri stable, grant_valid held; accept on cycle 6, busy rises next edge.
- AGE_TH=3, ch0 pri=200 and ch3 pri=1, both requesting continuously:
  - ch0 wins 3 times, ch3 age reaches 3
  - 4th decision: grant_id=11, grant_pri=255
  - ch3 age then clears to 0
- Assert rst_n=0 mid-BUSY and pulse done during OFFER -> immediate reset values; done in OFFER does not end the grant.
